// File: rtl/ifu_pkg.sv
// Shared IFU cache types and constants used by the miss/fill controller
// and its PLRU helper.
package ifu_pkg;

   localparam int IFU_WAYS_NUM      = 16;
   localparam int WAY_IDX_WIDTH     = $clog2(IFU_WAYS_NUM);
   localparam int PLRU_BITS         = IFU_WAYS_NUM - 1;
   localparam int CL_WIDTH          = 128;
   localparam int OFFSET_WIDTH      = 4;
   localparam int TAG_ADDRESS_WIDTH = 32 - OFFSET_WIDTH;

   typedef struct packed {
      logic        fill_requested_address_valid;
      logic [31:0] fill_requested_address;
   } t_cache2i_mem_req;

   typedef struct packed {
      logic                valid;
      logic [31:0]         address;
      logic [CL_WIDTH-1:0] filled_instruction;
   } t_i_mem2cache_rsp;

   typedef struct packed {
      logic        requested_instruction_valid;
      logic [31:0] requested_instruction;
   } t_cache2core_rsp;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      FILL,
      RSP
   } t_fill_state;

endpackage

// File: rtl/ifu_plru.sv
// Tree pseudo-LRU state for one cache set: a registered node vector,
// a combinational victim walk and an access update.
module ifu_plru
   import ifu_pkg::*;
#(
   parameter int WAYS_NUM = IFU_WAYS_NUM
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic                        access_valid,
   input  logic [$clog2(WAYS_NUM)-1:0] access_way,
   output logic [$clog2(WAYS_NUM)-1:0] victim_way
);

   localparam int IDX_W  = $clog2(WAYS_NUM);
   localparam int NODES  = WAYS_NUM - 1;
   localparam int NODE_W = $clog2(NODES);

   logic [NODES-1:0] plru_reg;
   logic [NODES-1:0] plru_next;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         plru_reg <= '0;
      end else begin
         plru_reg <= plru_next;
      end
   end

   // Node n has children 2n+1 (left) and 2n+2 (right); bit 0 steers left.
   always_comb begin : victim_walk
      int node;
      node       = 0;
      victim_way = '0;
      for (int lvl = 0; lvl < IDX_W; lvl++) begin
         victim_way[IDX_W-1-lvl] = plru_reg[NODE_W'(node)];
         node = 2 * node + 1 + int'(plru_reg[NODE_W'(node)]);
      end
   end

   always_comb begin : access_update
      int node;
      node      = 0;
      plru_next = plru_reg;
      if (access_valid) begin
         for (int lvl = 0; lvl < IDX_W; lvl++) begin
            plru_next[NODE_W'(node)] = ~access_way[IDX_W-1-lvl];
            node = 2 * node + 1 + int'(access_way[IDX_W-1-lvl]);
         end
      end
   end

endmodule

// File: rtl/ifu_fill_ctrl.sv
// IFU I-cache miss/fill controller: one line fill per miss, victim selection,
// array write and critical-word return. Define IFU_FILL_TIMEOUT_EN to re-issue stalled fills.
module ifu_fill_ctrl
   import ifu_pkg::*;
#(
   parameter int WAYS_NUM     = IFU_WAYS_NUM,
   parameter int FILL_TIMEOUT = 255
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic                         miss_valid,
   input  logic [31:0]                  miss_address,
   input  logic                         hit_valid,
   input  logic [$clog2(WAYS_NUM)-1:0]  hit_way,
   input  logic [WAYS_NUM-1:0]          way_valid,
   output logic                         busy,
   output t_cache2i_mem_req             fill_req,
   input  t_i_mem2cache_rsp             fill_rsp,
   output logic                         fill_we,
   output logic [$clog2(WAYS_NUM)-1:0]  fill_way,
   output logic [TAG_ADDRESS_WIDTH-1:0] fill_tag,
   output logic [CL_WIDTH-1:0]          fill_data,
   output t_cache2core_rsp              core_rsp
);

   localparam int IDX_W     = $clog2(WAYS_NUM);
   localparam int WORDS_NUM = CL_WIDTH / 32;

   if (WAYS_NUM < 4 || (WAYS_NUM & (WAYS_NUM - 1)) != 0 ||
       FILL_TIMEOUT < 1 || FILL_TIMEOUT > 256) begin : g_bad_cfg
      $error("ifu_fill_ctrl: unsupported WAYS_NUM or FILL_TIMEOUT");
   end

   t_fill_state         state_reg, state_next;
   logic [31:0]         pending_reg, pending_next;
   logic [CL_WIDTH-1:0] line_reg, line_next;
   logic                busy_reg;

   logic                plru_acc_valid;
   logic [IDX_W-1:0]    plru_acc_way;
   logic [IDX_W-1:0]    victim_way;
   logic [IDX_W-1:0]    first_invalid;
   logic                any_invalid;
   logic [IDX_W-1:0]    chosen_way;
   logic                rsp_match;
   logic                wait_timeout;
   logic [31:0]         line_words [WORDS_NUM];
   logic                unused_bits;

   for (genvar gi = 0; gi < WORDS_NUM; gi++) begin : g_words
      assign line_words[gi] = line_reg[gi*32 +: 32];
   end

   // Descending scan so the lowest-index invalid way is the one left standing.
   always_comb begin
      any_invalid   = 1'b0;
      first_invalid = '0;
      for (int i = WAYS_NUM - 1; i >= 0; i--) begin
         if (!way_valid[i]) begin
            any_invalid   = 1'b1;
            first_invalid = IDX_W'(i);
         end
      end
   end

   assign chosen_way  = any_invalid ? first_invalid : victim_way;
   assign rsp_match   = fill_rsp.valid &&
                        (fill_rsp.address[31:OFFSET_WIDTH] == pending_reg[31:OFFSET_WIDTH]);
   assign unused_bits = ^{pending_reg[1:0], fill_rsp.address[OFFSET_WIDTH-1:0]};

   ifu_plru #(
      .WAYS_NUM (WAYS_NUM)
   ) u_plru (
      .Clk          (Clk),
      .Rst          (Rst),
      .access_valid (plru_acc_valid),
      .access_way   (plru_acc_way),
      .victim_way   (victim_way)
   );

`ifdef IFU_FILL_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(FILL_TIMEOUT - 1);

   logic [7:0] wait_cnt_reg, wait_cnt_next;

   // The request goes back out on the cycle the count would reach FILL_TIMEOUT.
   assign wait_timeout = (state_reg == WAIT) && (wait_cnt_reg == WAIT_LAST);

   always_comb begin
      wait_cnt_next = '0;
      if (state_reg == WAIT && state_next == WAIT) begin
         wait_cnt_next = wait_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wait_cnt_reg <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
      end
   end
`else
   assign wait_timeout = 1'b0;
`endif

   always_comb begin
      state_next     = state_reg;
      pending_next   = pending_reg;
      line_next      = line_reg;
      plru_acc_valid = hit_valid;
      plru_acc_way   = hit_way;
      fill_req       = '0;
      fill_we        = 1'b0;
      fill_way       = '0;
      fill_tag       = '0;
      fill_data      = '0;
      core_rsp       = '0;
      unique case (state_reg)
         IDLE: begin
            if (miss_valid) begin
               pending_next = miss_address;
               state_next   = REQ;
            end
         end
         REQ: begin
            fill_req.fill_requested_address_valid = 1'b1;
            fill_req.fill_requested_address = {pending_reg[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            state_next = WAIT;
         end
         WAIT: begin
            if (rsp_match) begin
               line_next  = fill_rsp.filled_instruction;
               state_next = FILL;
            end else if (wait_timeout) begin
               state_next = REQ;
            end
         end
         FILL: begin
            // The refill counts as the access; a concurrent hit is dropped.
            fill_we        = 1'b1;
            fill_way       = chosen_way;
            fill_tag       = pending_reg[31:OFFSET_WIDTH];
            fill_data      = line_reg;
            plru_acc_valid = 1'b1;
            plru_acc_way   = chosen_way;
            state_next     = RSP;
         end
         RSP: begin
            core_rsp.requested_instruction_valid = 1'b1;
            core_rsp.requested_instruction       = line_words[pending_reg[3:2]];
            state_next                           = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_reg   <= IDLE;
         pending_reg <= '0;
         line_reg    <= '0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         line_reg    <= line_next;
         busy_reg    <= (state_next != IDLE);
      end
   end

   assign busy = busy_reg;

endmodule

// File: tb/tb_ifu_fill_ctrl.sv
// Directed scoreboard bench for ifu_fill_ctrl: expected requests, fills and
// core responses are queued with their cycle stamps and checked as they appear.
module tb_ifu_fill_ctrl;
   import ifu_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             miss_valid;
   logic [31:0]      miss_address;
   logic             hit_valid;
   logic [3:0]       hit_way;
   logic [15:0]      way_valid;
   logic             busy;
   t_cache2i_mem_req fill_req;
   t_i_mem2cache_rsp fill_rsp;
   logic             fill_we;
   logic [3:0]       fill_way;
   logic [27:0]      fill_tag;
   logic [127:0]     fill_data;
   t_cache2core_rsp  core_rsp;

   ifu_fill_ctrl dut (
      .Clk          (clk),
      .Rst          (rst),
      .miss_valid   (miss_valid),
      .miss_address (miss_address),
      .hit_valid    (hit_valid),
      .hit_way      (hit_way),
      .way_valid    (way_valid),
      .busy         (busy),
      .fill_req     (fill_req),
      .fill_rsp     (fill_rsp),
      .fill_we      (fill_we),
      .fill_way     (fill_way),
      .fill_tag     (fill_tag),
      .fill_data    (fill_data),
      .core_rsp     (core_rsp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h2222_1111;
   localparam logic [31:0] A2 = 32'h3333_2222, A3 = 32'h4444_3333;
   localparam logic [31:0] B0 = 32'hB0B0_0000, B1 = 32'hB1B1_1111;
   localparam logic [31:0] B2 = 32'hB2B2_2222, B3 = 32'hB3B3_3333;
   localparam logic [31:0] C0 = 32'hC0C0_0101, C1 = 32'hC1C1_1212;
   localparam logic [31:0] C2 = 32'hC2C2_2323, C3 = 32'hC3C3_3434;
   localparam logic [127:0] LINE_A = {A3, A2, A1, A0};
   localparam logic [127:0] LINE_B = {B3, B2, B1, B0};
   localparam logic [127:0] LINE_C = {C3, C2, C1, C0};
   localparam logic [127:0] LINE_D = 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;

   typedef struct { int cyc; logic [31:0] addr; } req_exp_t;
   typedef struct { int cyc; logic [3:0] way; logic [27:0] tag; logic [127:0] data; } fill_exp_t;
   typedef struct { int cyc; logic [31:0] instr; } core_exp_t;

   req_exp_t  req_q[$];
   fill_exp_t fill_q[$];
   core_exp_t core_q[$];
   req_exp_t  r;
   fill_exp_t f;
   core_exp_t c;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("[%0d] %s observed=%h expected=%h", cyc, tag, obs, exp);
   endtask

   // Output monitor: every DUT event must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (fill_req.fill_requested_address_valid) begin
            chk("req_expected", 192'(req_q.size() != 0), 192'(1));
            if (req_q.size() != 0) begin
               r = req_q.pop_front();
               chk("fill_req", {32'(cyc), fill_req.fill_requested_address}, {32'(r.cyc), r.addr});
            end
         end
         if (fill_we) begin
            chk("fill_expected", 192'(fill_q.size() != 0), 192'(1));
            if (fill_q.size() != 0) begin
               f = fill_q.pop_front();
               chk("fill_we", {32'(cyc), fill_way, fill_tag, fill_data}, {32'(f.cyc), f.way, f.tag, f.data});
            end
         end
         if (core_rsp.requested_instruction_valid) begin
            chk("core_expected", 192'(core_q.size() != 0), 192'(1));
            if (core_q.size() != 0) begin
               c = core_q.pop_front();
               chk("core_rsp", {32'(cyc), core_rsp.requested_instruction}, {32'(c.cyc), c.instr});
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue_miss(input logic [31:0] addr);
      miss_valid   = 1'b1;
      miss_address = addr;
      req_q.push_back('{cyc + 1, {addr[31:4], 4'h0}});
      tick();
      miss_valid   = 1'b0;
      miss_address = '0;
   endtask

   task automatic respond(input logic [31:0] addr, input logic [127:0] line, input bit match,
                          input logic [3:0] way, input logic [31:0] instr);
      fill_rsp.valid              = 1'b1;
      fill_rsp.address            = addr;
      fill_rsp.filled_instruction = line;
      if (match) begin
         fill_q.push_back('{cyc + 1, way, addr[31:4], line});
         core_q.push_back('{cyc + 2, instr});
      end
      tick();
      fill_rsp = '0;
   endtask

   initial begin
      miss_valid   = 1'b0;
      miss_address = '0;
      hit_valid    = 1'b0;
      hit_way      = '0;
      way_valid    = '0;
      fill_rsp     = '0;
      rst          = 1'b1;
      tick(3);
      chk("reset_outputs", {busy, fill_req, fill_we, fill_way, fill_tag, fill_data, core_rsp},
          192'(0));
      rst = 1'b0;
      tick();

      // Basic miss, all ways invalid, reply four cycles after the request.
      issue_miss(32'h0000_1238);
      chk("busy_in_fill", 192'(busy), 192'(1));
      tick(4);
      respond(32'h0000_1230, LINE_A, 1'b1, 4'd0, A2);
      tick(3);
      chk("busy_after_basic", 192'(busy), 192'(0));

      // PLRU victims with every way valid and fresh tree state.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      way_valid = 16'hFFFF;
      hit_valid = 1'b1;
      hit_way   = 4'd0;
      tick();
      hit_valid = 1'b0;
      issue_miss(32'h0000_ABCC);
      tick(2);
      respond(32'h0000_ABC0, LINE_B, 1'b1, 4'd8, B3);
      tick(3);
      issue_miss(32'h0000_5674);
      tick(2);
      respond(32'h0000_5670, LINE_C, 1'b1, 4'd4, C1);
      tick(3);
      // Hit and miss together: miss is taken, hit on way 12 still steers the tree.
      hit_valid = 1'b1;
      hit_way   = 4'd12;
      issue_miss(32'h0000_9990);
      hit_valid = 1'b0;
      tick(2);
      respond(32'h0000_9990, LINE_D, 1'b1, 4'd2, 32'h0BAD_F00D);
      tick(3);

      // Address filter, with ways 5 and 9 invalid.
      way_valid = 16'hFDDF;
      issue_miss(32'h0000_1230);
      tick(2);
      respond(32'h0000_2000, LINE_D, 1'b0, 4'd0, 32'h0);
      chk("busy_after_mismatch", 192'(busy), 192'(1));
      tick();
      respond(32'h0000_1230, LINE_A, 1'b1, 4'd5, A0);
      tick(3);
      chk("busy_after_filter", 192'(busy), 192'(0));

      // Miss presented while busy must not start another fill.
      way_valid = 16'h0000;
      issue_miss(32'h0000_7778);
      tick();
      miss_valid   = 1'b1;
      miss_address = 32'h0000_4440;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("busy_stall", 192'(busy), 192'(1));
      end
      miss_valid   = 1'b0;
      miss_address = '0;
      respond(32'h0000_7770, LINE_C, 1'b1, 4'd0, C2);
      tick(3);

      // Reset while waiting; the late response must be ignored.
      issue_miss(32'h0000_3330);
      tick(2);
      rst = 1'b1;
      #1;
      chk("reset_mid_outputs", {busy, fill_req, fill_we, core_rsp}, 192'(0));
      tick();
      rst = 1'b0;
      respond(32'h0000_3330, LINE_A, 1'b0, 4'd0, 32'h0);
      tick(3);
      chk("busy_after_reset", 192'(busy), 192'(0));

`ifdef IFU_FILL_TIMEOUT_EN
      // No reply: the same request reappears 256 cycles after the first.
      issue_miss(32'h0000_5550);
      req_q.push_back('{cyc + 256, 32'h0000_5550});
      tick(260);
      respond(32'h0000_5550, LINE_B, 1'b1, 4'd0, B0);
      tick(3);
`endif

      chk("req_queue_empty", 192'(req_q.size()), 192'(0));
      chk("fill_queue_empty", 192'(fill_q.size()), 192'(0));
      chk("core_queue_empty", 192'(core_q.size()), 192'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ifu_fill_ctrl.md
Name: ifu_fill_ctrl

Overview:
- Miss/fill controller for the IFU instruction cache; sits between the cache lookup stage, the tag/data arrays and the i_mem fill port.
- On a lookup miss it issues one line-fill request to i_mem, waits for the matching 128-bit line, and picks a victim way (first invalid, else tree-PLRU).
- It then writes the line and tag into the arrays and returns the requested 32-bit instruction to the core.
- It also tracks PLRU state on lookup hits.

Parameters:
- WAYS_NUM, 16, number of ways; power of two; matches ifu_pkg.
- FILL_TIMEOUT, 255, WAIT-state cycles before a fill request is re-issued; used only with IFU_FILL_TIMEOUT_EN.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous, active-high reset
- miss_valid  in  1  lookup missed this cycle
- miss_address  in  32  PC of the missing fetch
- hit_valid  in  1  lookup hit this cycle
- hit_way  in  4  way that hit
- way_valid  in  16  valid bits of all ways in the set
- busy  out  1  fill in progress; lookup must stall
- fill_req  out  t_cache2i_mem_req (33)  fill request to i_mem
- fill_rsp  in  t_i_mem2cache_rsp (161)  line returned by i_mem
- fill_we  out  1  array write strobe
- fill_way  out  4  way to write
- fill_tag  out  28  tag written, pc[31:4]
- fill_data  out  128  line written
- core_rsp  out  t_cache2core_rsp (33)  instruction to the core

Behaviour:
- Reset: Rst is asynchronous and active-high. It forces state IDLE, all outputs 0, pending address 0 and PLRU bits 0. A reset mid-fill abandons the fill; a later fill_rsp is ignored because the block is in IDLE.
- FSM states: IDLE, REQ, WAIT, FILL, RSP. busy = (state != IDLE), registered.
- IDLE:
  - On miss_valid, latch miss_address and go to REQ.
  - With hit_valid and miss_valid both high, miss wins; the PLRU update from the hit still applies.
- REQ:
  - For exactly one cycle, fill_req.fill_requested_address_valid=1 and fill_requested_address={pending[31:4],4'h0}.
  - Next state is WAIT.
- WAIT:
  - On fill_rsp.valid with fill_rsp.address[31:4]==pending[31:4], capture filled_instruction and go to FILL.
  - A response with a mismatched address is dropped.
- FILL:
  - For one cycle: fill_we=1, fill_tag=pending[31:4], fill_data=captured line.
  - fill_way = lowest-index way whose way_valid bit is 0. If all ways are valid, fill_way = PLRU victim.
  - The PLRU bits are updated as an access to fill_way. Next state is RSP.
- RSP:
  - For one cycle: core_rsp.requested_instruction_valid=1 and requested_instruction = line word pending[3:2], where word 0 is bits [31:0].
  - Next state is IDLE.
- Latency: miss accepted at cycle 0 → fill_req at cycle 1. If the matching fill_rsp arrives at cycle N, fill_we is at N+1 and core_rsp at N+2.
- miss_valid while busy is ignored; the stalled lookup re-presents the miss later.
- PLRU:
  - 15 node bits; node i has children 2i+1 (left) and 2i+2 (right). Leaves map to ways 0..15 left to right.
  - Victim walk: at each node, bit=0 → left, bit=1 → right.
  - Access of way w: every node on the path to w is set to point away from w (1 if w lies left, 0 if right).
  - hit_valid updates the PLRU in every state except FILL, where the fill update takes precedence and the hit is ignored.

Optional Feature:
IFU_FILL_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches FILL_TIMEOUT with no matching response, the FSM returns to REQ and re-issues the same request. The counter is 0 in all other states.
- Undefined: WAIT waits indefinitely, and no counter logic is synthesised.

Decomposition:
- ifu_pkg gains:
  - WAY_IDX_WIDTH = $clog2(WAYS_NUM)
  - OFFSET_WIDTH = 4
  - t_fill_state enum {IDLE, REQ, WAIT, FILL, RSP}
- Existing CL_WIDTH, TAG_ADDRESS_WIDTH, PLRU_BITS and the three structs are reused.
- Sub-module ifu_plru: holds the 15-bit PLRU register. It takes access_valid/access_way and produces victim_way combinationally.

Test Plan:
- Basic miss: miss at 0x0000_1238, all ways invalid, i_mem replies 4 cycles after the request with line {W3,W2,W1,W0}. Required: fill_req address 0x0000_1230; fill_we with way 0 and tag 0x0000123; core_rsp = W2 two cycles after the response; busy low afterwards.
- PLRU victim: all ways valid, PLRU reset, then a hit on way 0 followed by a miss. Required: fill_way = 8. A second miss with no hits in between gives fill_way = 4.
- Address filter: during WAIT, a response for 0x0000_2000 arrives before the one for the pending 0x0000_1230. Required: the first is ignored, the second is filled, and exactly one fill_we occurs.
- Busy stall: a miss_valid during WAIT. Required: no second fill_req and no state change.
- Reset mid-operation: Rst asserted in WAIT, then a response arrives after release. Required: outputs 0, no fill_we, no core_rsp.
- Timeout (IFU_FILL_TIMEOUT_EN, FILL_TIMEOUT=255): no response. Required: fill_req re-issued 256 cycles after the first, with the same address.
